// File: rtl/gate_tt_sequencer.sv
// Truth-table test controller for the 3-input / 2-output basic-gate block.
// A start pulse sweeps {a,b,c} = 0..7 onto the gate block. Each pattern is
// settled, then {f,e} is sampled and checked against EXP_TABLE. The result is
// reported as a per-pattern fail map, a fail count, the first failing index,
// and pass/done status.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        single-cycle sweep request (accepted in IDLE only)
//   abort        synchronous abort of a running sweep
//   dut_out      gate block outputs {f,e}
//   dut_in       gate block inputs {a,b,c}; zero while not sweeping
//   busy         high in DRIVE/SAMPLE/CHECK
//   done         one-cycle pulse when a sweep completes
//   pass         valid after done; 1 = no mismatches
//   fail_cnt     number of mismatching patterns (0..8)
//   fail_map     bit i set = pattern i mismatched
//   first_fail   index of the first mismatch; valid when fail_cnt != 0
module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_TABLE     = 16'hF8A8,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] dut_out,
  output logic [2:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_cnt,
  output logic [7:0] fail_map,
  output logic [2:0] first_fail
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FCNT_W = 4;
  localparam int unsigned MAP_W  = 8;
  localparam int unsigned OUT_W  = 2;

  localparam logic [IDX_W-1:0] PAT_LAST      = IDX_W'(7);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e              state_q,      state_d;
  logic [IDX_W-1:0]    idx_q,        idx_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [OUT_W-1:0]    sample_q,     sample_d;
  logic [IDX_W-1:0]    dut_in_q,     dut_in_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic                pass_q,       pass_d;
  logic [FCNT_W-1:0]   fail_cnt_q,   fail_cnt_d;
  logic [MAP_W-1:0]    fail_map_q,   fail_map_d;
  logic [IDX_W-1:0]    first_fail_q, first_fail_d;

  logic [OUT_W-1:0]    exp_c;
  logic                mismatch_c;

  // Expected {f,e} for the pattern currently being checked.
  assign exp_c      = EXP_TABLE[{idx_q, 1'b0} +: OUT_W];
  assign mismatch_c = (sample_q != exp_c);

  // Next-state and next-output logic; outputs are derived from the next state
  // so that the registered outputs line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    fail_map_d   = fail_map_q;
    first_fail_d = first_fail_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    dut_in_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          fail_cnt_d   = '0;
          fail_map_d   = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          idx_d        = '0;
          cnt_d        = SETTLE_RELOAD;
          state_d      = S_DRIVE;
        end
      end

      S_DRIVE: begin
        // Counter reloads to SETTLE_CYCLES-1, so the pattern is held exactly
        // SETTLE_CYCLES cycles here.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        sample_d = dut_out;
        state_d  = S_CHECK;
      end

      S_CHECK: begin
        if (mismatch_c) begin
          fail_map_d[idx_q] = 1'b1;
          fail_cnt_d        = fail_cnt_q + FCNT_W'(1);
          if (fail_cnt_q == '0) begin
            first_fail_d = idx_q;
          end
        end
        if ((idx_q == PAT_LAST) || (STOP_ON_FAIL && mismatch_c)) begin
          state_d = S_DONE;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = SETTLE_RELOAD;
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any sweep progress; partial fail results are kept.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end

    busy_d   = (state_d == S_DRIVE) || (state_d == S_SAMPLE) || (state_d == S_CHECK);
    done_d   = (state_d == S_DONE);
    dut_in_d = busy_d ? idx_d : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      sample_q     <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      fail_map_q   <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_map_q   <= fail_map_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign fail_map   = fail_map_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench for gate_tt_sequencer. Three instances share clock, reset,
// start and abort: u0 default parameters, u1 STOP_ON_FAIL=1, u2 SETTLE_CYCLES=1.
// Each drives its own model of the gate block, faulted according to 'mode'.
module tb_gate_tt_sequencer;

  typedef struct {
    int lat;
    int pass;
    int cnt;
    int map;
    int ff;
    int t0;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] dout_w  [3];
  logic [2:0] din_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic [3:0] fcnt_w  [3];
  logic [7:0] fmap_w  [3];
  logic [2:0] ffail_w [3];

  int   mode;
  int   cyc;
  int   t0;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate block model: mode 0 correct, 1 e stuck-at-0, 2 f inverted.
  function automatic logic [1:0] gate(input logic [2:0] i, input int m);
    logic e, f;
    e = i[2] & i[1];
    f = i[1] | i[0];
    if (m == 1) e = 1'b0;
    if (m == 2) f = ~f;
    return {f, e};
  endfunction

  assign dout_w[0] = gate(din_w[0], mode);
  assign dout_w[1] = gate(din_w[1], mode);
  assign dout_w[2] = gate(din_w[2], mode);

  gate_tt_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dout_w[0]),
    .dut_in(din_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_cnt(fcnt_w[0]), .fail_map(fmap_w[0]), .first_fail(ffail_w[0]));

  gate_tt_sequencer #(.STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dout_w[1]),
    .dut_in(din_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_cnt(fcnt_w[1]), .fail_map(fmap_w[1]), .first_fail(ffail_w[1]));

  gate_tt_sequencer #(.SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dout_w[2]),
    .dut_in(din_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .fail_cnt(fcnt_w[2]), .fail_map(fmap_w[2]), .first_fail(ffail_w[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int lat, input int pass, input int cnt,
                      input int map, input int ff);
    exp_t e;
    e.lat = lat; e.pass = pass; e.cnt = cnt; e.map = map; e.ff = ff; e.t0 = t0;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Pulse start for one cycle; t0 is the edge count of the sampling edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  // Monitor: every done pulse must match the oldest expectation for its instance.
  task automatic check_done(input int k);
    exp_t e;
    bit   got;
    got = 1'b1;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front(); else got = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else got = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else got = 1'b0;
    endcase
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done u%0d actual done=1 expected no done (t=%0t)", k, $time);
    end else begin
      chk($sformatf("u%0d_latency", k), cyc - e.t0 + 1, e.lat);
      chk($sformatf("u%0d_pass", k), int'(pass_w[k]), e.pass);
      chk($sformatf("u%0d_fail_cnt", k), int'(fcnt_w[k]), e.cnt);
      chk($sformatf("u%0d_fail_map", k), int'(fmap_w[k]), e.map);
      if (e.cnt != 0) chk($sformatf("u%0d_first_fail", k), int'(ffail_w[k]), e.ff);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) check_done(k);
      end
    end
  end

  task automatic chk_zero(input int k, input string tag);
    chk($sformatf("%s_u%0d_outputs", tag, k),
        int'({din_w[k], busy_w[k], done_w[k], pass_w[k], fcnt_w[k], fmap_w[k], ffail_w[k]}), 0);
  endtask

  initial begin
    int bound;
    cyc    = 0;
    t0     = 0;
    checks = 0;
    errors = 0;
    mode   = 0;
    start  = 1'b0;
    abort  = 1'b0;
    rst_n  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep; u0 pattern sequence checked cycle by cycle.
    mode = 0;
    pulse_start();
    push(0, 33, 1, 0, 8'h00, 0);
    push(1, 33, 1, 0, 8'h00, 0);
    push(2, 25, 1, 0, 8'h00, 0);
    for (int k = 0; k < 32; k++) begin
      if (k % 4 == 0) begin
        chk($sformatf("seq_dut_in_k%0d", k), int'(din_w[0]), k / 4);
        chk($sformatf("seq_busy_k%0d", k), int'(busy_w[0]), 1);
      end
      @(negedge clk);
    end
    repeat (8) @(negedge clk);

    // e stuck-at-0: patterns 6 and 7 fail.
    mode = 1;
    pulse_start();
    push(0, 33, 0, 2, 8'hC0, 6);
    push(1, 29, 0, 1, 8'h40, 6);
    push(2, 25, 0, 2, 8'hC0, 6);
    repeat (40) @(negedge clk);

    // f inverted: every pattern fails; STOP_ON_FAIL stops at pattern 0.
    mode = 2;
    pulse_start();
    push(0, 33, 0, 8, 8'hFF, 0);
    push(1, 5, 0, 1, 8'h01, 0);
    push(2, 25, 0, 8, 8'hFF, 0);
    repeat (40) @(negedge clk);

    // Abort while u0 drives pattern 3.
    mode = 0;
    pulse_start();
    bound = 0;
    while (din_w[0] != 3'd3 && bound < 40) begin
      @(negedge clk);
      bound++;
    end
    chk("abort_reach_pattern3", int'(din_w[0]), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_dut_in", int'(din_w[0]), 0);
    chk("abort_pass", int'(pass_w[0]), 0);
    chk("abort_fail_cnt", int'(fcnt_w[0]), 0);
    chk("abort_u2_busy", int'(busy_w[2]), 0);
    repeat (40) @(negedge clk);

    // Clean sweep with an ignored start 10 cycles in.
    pulse_start();
    push(0, 33, 1, 0, 8'h00, 0);
    push(1, 33, 1, 0, 8'h00, 0);
    push(2, 25, 1, 0, 8'h00, 0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("rerun_pass_held", int'(pass_w[0]), 1);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", int'(busy_w[0]), 0);
    repeat (5) @(negedge clk);
    chk("start_abort_busy_later", int'(busy_w[0]), 0);
    chk("start_abort_dut_in", int'(din_w[0]), 0);

    // Asynchronous reset mid-sweep.
    mode = 2;
    pulse_start();
    push(1, 5, 0, 1, 8'h01, 0);
    repeat (10) @(negedge clk);
    chk("pre_reset_fail_cnt", int'(fcnt_w[0]), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k, "async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_busy_u0", int'(busy_w[0]), 0);
    chk("post_reset_busy_u2", int'(busy_w[2]), 0);
    chk("post_reset_dut_in", int'(din_w[0]), 0);

    // All expected done pulses must have arrived.
    bound = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    chk("pending_expectations", q0.size() + q1.size() + q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
- Built-in truth-table test controller for the 3-input / 2-output basic-gate block.
- On a start pulse it drives all 8 input patterns {a,b,c} = 0..7 onto the gate block in order and waits a settle time for each.
- It samples {f,e}, compares the sample against a parameterised expected table, and reports a per-pattern fail map, a fail count and pass/done status.
- Sits between a top-level test/control register and the combinational gate block; it is the only driver of the gate inputs while busy.

Parameters:
- SETTLE_CYCLES, 2, cycles each pattern is held before sampling; legal range 1..15.
- EXP_TABLE, 16'hF8A8, expected outputs; bits [2i+1:2i] = {f,e} for pattern i = {a,b,c}. The default encodes e = a&b, f = b|c.
- STOP_ON_FAIL, 0, when 1 the sweep ends at the first mismatching pattern.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep
- abort  in  1  synchronous abort of a running sweep
- dut_out  in  2  gate block outputs {f,e}
- dut_in  out  3  gate block inputs {a,b,c}
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when a sweep completes (not on abort)
- pass  out  1  valid after done; 1 = no mismatches
- fail_cnt  out  4  number of mismatching patterns, 0..8
- fail_map  out  8  bit i set = pattern i mismatched
- first_fail  out  3  index of first mismatch; valid when fail_cnt != 0

Behaviour:
- Reset (rst_n low, async): state IDLE; dut_in=0, busy=0, done=0, pass=0, fail_cnt=0, fail_map=0, first_fail=0, idx=0, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, CHECK, DONE.
- IDLE:
  - start=1 and abort=0 → clear fail_cnt, fail_map, first_fail and pass.
  - Same transition: idx=0, settle counter=SETTLE_CYCLES-1, go to DRIVE.
- DRIVE:
  - dut_in=idx.
  - Counter nonzero → decrement it; counter zero → go to SAMPLE.
  - Pattern is held for exactly SETTLE_CYCLES cycles in DRIVE.
- SAMPLE:
  - dut_in still = idx.
  - Register dut_out into sample_q; go to CHECK.
- CHECK: compare sample_q with EXP_TABLE[2*idx+:2]. On mismatch:
  - set fail_map[idx];
  - increment fail_cnt;
  - load first_fail=idx if fail_cnt was 0.
- CHECK next state:
  - idx==7, or (STOP_ON_FAIL and mismatch) → DONE.
  - Otherwise idx+1, counter reload, → DRIVE.
- DONE:
  - done=1 for exactly one cycle.
  - pass=(final fail_cnt==0) is registered in the same cycle and held.
  - Next state: IDLE.
- busy=1 in DRIVE, SAMPLE and CHECK; 0 in IDLE and DONE.
- dut_in=0 in IDLE and DONE.
- Latency: start sampled at edge N → DRIVE from N+1; full sweep spends 8*(SETTLE_CYCLES+2) cycles in DRIVE/SAMPLE/CHECK. Default 32 cycles; done is high in cycle N+33.
- start while busy or in DONE: ignored, no restart.
- abort=1 in any non-IDLE state: next state IDLE.
  - No done pulse; pass=0; dut_in=0.
  - fail_cnt, fail_map and first_fail keep their partial values.
- start and abort in the same IDLE cycle: abort wins, stay IDLE.
- fail_cnt saturation is unnecessary (max 8 fits in 4 bits); idx never wraps past 7.
- Reset mid-sweep: immediate return to reset values, no done.

Test Plan:
- Correct DUT model (e=a&b, f=b|c), default params, 1-cycle start → dut_in steps 0..7, each held 2 cycles then held through SAMPLE/CHECK; done pulse 33 cycles after start; pass=1, fail_cnt=0, fail_map=8'h00.
- Faulty model with e stuck-at-0 → mismatches at patterns 6,7; pass=0, fail_cnt=2, fail_map=8'hC0, first_fail=6.
- STOP_ON_FAIL=1 with f inverted → first CHECK (pattern 0) fails; done 5 cycles after start; fail_cnt=1, fail_map=8'h01, first_fail=0.
- Abort asserted while dut_in=3 → next cycle busy=0, dut_in=0, no done, pass=0; then a new start runs a full clean sweep to pass=1.
- Start pulses while busy, and start+abort together in IDLE → no restart and no extra done; the sweep timing is unchanged by the ignored start.
- rst_n pulled low mid-sweep (asynchronously, between edges) → all outputs 0 immediately; after release the block idles until the next start.
- SETTLE_CYCLES=1 → each pattern occupies 3 cycles; done 25 cycles after start.
